// File: rtl/spi_packet_rx.sv
// spi_packet_rx
// SPI mode-0 slave front end. Receives 16-bit frames (MSB first) from the MCU,
// oversampled in the clk domain, and hands each complete frame to the packet
// decoder as two bytes plus a one-cycle ready strobe. A chip select that rises
// part-way through a frame raises a one-cycle frameError and the partial bits
// are thrown away.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous, active-high reset
//   sck        - SPI clock from MCU (asynchronous, CPOL=0 CPHA=0)
//   sdi        - SPI data from MCU (asynchronous, MSB first)
//   cs         - chip select from MCU (asynchronous, active-low)
//   spiPacket1 - first byte of the last complete frame
//   spiPacket2 - second byte of the last complete frame
//   ready      - one-cycle pulse when spiPacket1/spiPacket2 are reloaded
//   frameError - one-cycle pulse when cs deasserts mid-frame
module spi_packet_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       sdi,
  input  logic       cs,
  output logic [7:0] spiPacket1,
  output logic [7:0] spiPacket2,
  output logic       ready,
  output logic       frameError
);

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    IDLE  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic [2:0]  r_sckSync;
  logic [1:0]  r_sdiSync;
  logic [1:0]  r_csSync;

  logic [1:0]  r_armCnt;
  logic [3:0]  r_bitCnt;
  logic [15:0] r_shiftReg;
  logic        r_frameDone;
  logic [7:0]  r_packet1;
  logic [7:0]  r_packet2;
  logic        r_ready;
  logic        r_frameError;

  logic        w_sckRise;
  logic        w_csHigh;
  logic        w_sdiBit;
  logic        w_startFrame;
  logic        w_shiftEn;
  logic        w_abort;

  assign w_sckRise = r_sckSync[1] & ~r_sckSync[2];
  assign w_csHigh  = r_csSync[1];
  assign w_sdiBit  = r_sdiSync[1];

  // Bring the three SPI pins into the clk domain. Index 0 is the first flop,
  // index 1 the synchronized value, and sck gets a third flop so a rising
  // edge can be seen as stage2=1/stage3=0. The cs chain preloads to the
  // deasserted level so reset never looks like a frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sckSync <= 3'b000;
      r_sdiSync <= 2'b00;
      r_csSync  <= 2'b11;
    end else begin
      r_sckSync <= {r_sckSync[1:0], sck};
      r_sdiSync <= {r_sdiSync[0], sdi};
      r_csSync  <= {r_csSync[0], cs};
    end
  end

  // State register for the receive FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARM;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and control decode. ARM only trusts the synchronized cs once
  // the chain has been refilled from the pin after reset (r_armCnt reaches 2);
  // otherwise the preloaded 1s would let a cs that was already low at reset
  // release sneak through as a frame start. In SHIFT a cs deassertion takes
  // priority over a coincident sck edge, so the abort test sees the bit count
  // from before that edge.
  always_comb begin
    w_nextState  = r_state;
    w_startFrame = 1'b0;
    w_shiftEn    = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ARM: begin
        if ((r_armCnt == 2'd2) && w_csHigh) begin
          w_nextState = IDLE;
        end
      end
      IDLE: begin
        if (!w_csHigh) begin
          w_nextState  = SHIFT;
          w_startFrame = 1'b1;
        end
      end
      SHIFT: begin
        if (w_csHigh) begin
          w_nextState = IDLE;
          w_abort     = (r_bitCnt != 4'd0);
        end else if (w_sckRise) begin
          w_shiftEn = 1'b1;
        end
      end
      default: begin
        w_nextState = ARM;
      end
    endcase
  end

  // Settling counter for ARM. It only runs while in ARM and is cleared by
  // reset, which is the only way back into ARM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_armCnt <= 2'd0;
    end else if ((r_state == ARM) && (r_armCnt != 2'd2)) begin
      r_armCnt <= r_armCnt + 2'd1;
    end
  end

  // Shift register and bit counter. The counter wraps 15 -> 0 so several
  // frames can follow each other inside one cs assertion. r_frameDone marks
  // the cycle after the 16th bit lands, at which point r_shiftReg already
  // holds the whole frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shiftReg  <= 16'h0000;
      r_bitCnt    <= 4'd0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= w_shiftEn && (r_bitCnt == 4'd15);
      if (w_startFrame) begin
        r_shiftReg <= 16'h0000;
        r_bitCnt   <= 4'd0;
      end else if (w_shiftEn) begin
        r_shiftReg <= {r_shiftReg[14:0], w_sdiBit};
        r_bitCnt   <= r_bitCnt + 4'd1;
      end
    end
  end

  // Output registers. The packet bytes change only on a completed frame, so
  // an aborted frame leaves the previous packet visible. ready and frameError
  // cannot coincide: a pending frameDone means the count just wrapped to 0,
  // and an abort needs a nonzero count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_packet1    <= 8'h00;
      r_packet2    <= 8'h00;
      r_ready      <= 1'b0;
      r_frameError <= 1'b0;
    end else begin
      r_ready      <= r_frameDone;
      r_frameError <= w_abort;
      if (r_frameDone) begin
        r_packet1 <= r_shiftReg[15:8];
        r_packet2 <= r_shiftReg[7:0];
      end
    end
  end

  assign spiPacket1 = r_packet1;
  assign spiPacket2 = r_packet2;
  assign ready      = r_ready;
  assign frameError = r_frameError;

endmodule

// File: tb/tb_spi_packet_rx.sv
// tb_spi_packet_rx
// Scoreboard bench for spi_packet_rx. Stimulus pushes the expected event
// (ready with packet bytes, or frameError with the retained bytes) together
// with the clk cycle it must appear in; an independent monitor pops and
// compares whenever the DUT pulses ready or frameError.
module tb_spi_packet_rx;

  typedef struct {
    bit         isErr;
    logic [7:0] p1;
    logic [7:0] p2;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       sck;
  logic       sdi;
  logic       cs;
  logic [7:0] spiPacket1;
  logic [7:0] spiPacket2;
  logic       ready;
  logic       frameError;

  int   checks = 0;
  int   errors = 0;
  int   cycCnt = 0;
  exp_t expQ[$];
  exp_t monE;

  spi_packet_rx dut (
    .clk        (clk),
    .reset      (reset),
    .sck        (sck),
    .sdi        (sdi),
    .cs         (cs),
    .spiPacket1 (spiPacket1),
    .spiPacket2 (spiPacket2),
    .ready      (ready),
    .frameError (frameError)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to pin down pulse latency.
  always @(posedge clk) begin
    cycCnt <= cycCnt + 1;
  end

  // Single comparison point shared by stimulus and monitor.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift nBits of data (MSB first) with sck = clk/8. When armed, every 16th
  // rising sck pushes the hand-computed frame it completes (expA, then expB),
  // due 4 cycles after that rise.
  task automatic applyStimulus(input logic [31:0] data, input int nBits, input bit armed,
                               input logic [15:0] expA, input logic [15:0] expB);
    exp_t e;
    for (int i = 0; i < nBits; i++) begin
      sdi = data[nBits-1-i];
      waitCycles(4);
      sck = 1'b1;
      if (armed && (((i + 1) % 16) == 0)) begin
        e.isErr = 1'b0;
        e.p1    = (i < 16) ? expA[15:8] : expB[15:8];
        e.p2    = (i < 16) ? expA[7:0]  : expB[7:0];
        e.cyc   = cycCnt + 4;
        expQ.push_back(e);
      end
      waitCycles(4);
      sck = 1'b0;
    end
  endtask

  // Raise cs and, if a frameError is due, push it with the bytes that must
  // still be showing; it is due 3 cycles after cs rises.
  task automatic raiseCs(input bit expectErr, input logic [7:0] p1, input logic [7:0] p2);
    exp_t e;
    if (expectErr) begin
      e.isErr = 1'b1;
      e.p1    = p1;
      e.p2    = p2;
      e.cyc   = cycCnt + 3;
      expQ.push_back(e);
    end
    cs = 1'b1;
  endtask

  // Monitor: every ready or frameError pulse must match the head of the
  // scoreboard in kind, payload and cycle; a pulse with nothing expected is
  // an error, and a stuck pulse shows up as a second, unexpected pop.
  always @(negedge clk) begin
    if (ready && frameError) begin
      checkOutput("ready_and_error_together", 32'd1, 32'd0);
    end
    if (ready || frameError) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_pulse", {30'd0, ready, frameError}, 32'd0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("pulse_kind_is_error", {31'd0, frameError}, {31'd0, monE.isErr});
        checkOutput("spiPacket1", {24'd0, spiPacket1}, {24'd0, monE.p1});
        checkOutput("spiPacket2", {24'd0, spiPacket2}, {24'd0, monE.p2});
        checkOutput("pulse_cycle", cycCnt, monE.cyc);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog expired actual=%0d expected=<20000 cycles", cycCnt);
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence.
  initial begin
    int waited;
    reset = 1'b1;
    cs    = 1'b1;
    sck   = 1'b0;
    sdi   = 1'b0;
    waitCycles(5);
    reset = 1'b0;
    waitCycles(1);
    checkOutput("reset_spiPacket1", {24'd0, spiPacket1}, 32'h0);
    checkOutput("reset_spiPacket2", {24'd0, spiPacket2}, 32'h0);
    checkOutput("reset_ready", {31'd0, ready}, 32'd0);
    checkOutput("reset_frameError", {31'd0, frameError}, 32'd0);
    waitCycles(8);

    $display("[TB] single frame 0xE35A");
    cs = 1'b0;
    waitCycles(4);
    applyStimulus(32'h0000E35A, 16, 1'b1, 16'hE35A, 16'h0000);
    waitCycles(4);
    raiseCs(1'b0, 8'h00, 8'h00);
    waitCycles(8);
    checkOutput("hold_after_E35A_p1", {24'd0, spiPacket1}, 32'hE3);
    checkOutput("hold_after_E35A_p2", {24'd0, spiPacket2}, 32'h5A);

    $display("[TB] back-to-back frames 0x1234 0xABCD");
    cs = 1'b0;
    waitCycles(4);
    applyStimulus(32'h1234ABCD, 32, 1'b1, 16'h1234, 16'hABCD);
    waitCycles(4);
    raiseCs(1'b0, 8'h00, 8'h00);
    waitCycles(8);

    $display("[TB] truncated 9-bit frame");
    cs = 1'b0;
    waitCycles(4);
    applyStimulus(32'h000001FF, 9, 1'b0, 16'h0000, 16'h0000);
    waitCycles(4);
    raiseCs(1'b1, 8'hAB, 8'hCD);
    waitCycles(8);
    checkOutput("hold_after_abort_p1", {24'd0, spiPacket1}, 32'hAB);
    checkOutput("hold_after_abort_p2", {24'd0, spiPacket2}, 32'hCD);

    $display("[TB] cs low through reset release, then frame 0x0F0F");
    reset = 1'b1;
    cs    = 1'b0;
    waitCycles(5);
    reset = 1'b0;
    waitCycles(4);
    applyStimulus(32'h0000FFFF, 16, 1'b0, 16'h0000, 16'h0000);
    waitCycles(4);
    raiseCs(1'b0, 8'h00, 8'h00);
    waitCycles(6);
    cs = 1'b0;
    waitCycles(4);
    applyStimulus(32'h00000F0F, 16, 1'b1, 16'h0F0F, 16'h0000);
    waitCycles(4);
    raiseCs(1'b0, 8'h00, 8'h00);
    waitCycles(8);

    $display("[TB] reset after 8 bits, then frame 0xFFE0");
    cs = 1'b0;
    waitCycles(4);
    applyStimulus(32'h000000FF, 8, 1'b0, 16'h0000, 16'h0000);
    reset = 1'b1;
    waitCycles(3);
    reset = 1'b0;
    waitCycles(2);
    checkOutput("midframe_reset_p1", {24'd0, spiPacket1}, 32'h0);
    checkOutput("midframe_reset_p2", {24'd0, spiPacket2}, 32'h0);
    raiseCs(1'b0, 8'h00, 8'h00);
    waitCycles(6);
    cs = 1'b0;
    waitCycles(4);
    applyStimulus(32'h0000FFE0, 16, 1'b1, 16'hFFE0, 16'h0000);
    waitCycles(4);
    raiseCs(1'b0, 8'h00, 8'h00);
    waitCycles(8);

    waited = 0;
    while ((expQ.size() != 0) && (waited < 50)) begin
      waitCycles(1);
      waited++;
    end
    checkOutput("scoreboard_drained", expQ.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
